// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int INSTR_W    = 32;
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;

  localparam logic [INSTR_W-1:0] DEF_RESET_PC  = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] DEF_NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DROP = 2'd3
  } fetch_state_e;

  function automatic logic [INSTR_W-1:0] pc_plus4(input logic [INSTR_W-1:0] pc);
    return pc + 32'd4;
  endfunction

  function automatic logic [INSTR_W-1:0] word_align(input logic [INSTR_W-1:0] addr);
    return {addr[INSTR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory, redirect and decode-side handshake bundle of the fetch stage.
interface fetch_if;
  import fetch_pkg::*;

  logic               imem_req;
  logic [INSTR_W-1:0] imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               redirect;
  logic [INSTR_W-1:0] redirect_pc;
  logic               id_ready;
  logic               id_valid;
  logic [INSTR_W-1:0] id_instr;
  logic [5:0]         id_opcode;
  logic [INSTR_W-1:0] id_pc4;

  modport master (
    output imem_req, imem_addr, id_valid, id_instr, id_opcode, id_pc4,
    input  imem_ack, imem_rdata, redirect, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, id_valid, id_instr, id_opcode, id_pc4,
    output imem_ack, imem_rdata, redirect, redirect_pc, id_ready
  );

endinterface

// File: rtl/fetch_hold_buf.sv
// One-entry skid buffer for an instruction word and its pc+4 while decode stalls.
module fetch_hold_buf
  import fetch_pkg::*;
#(
  parameter logic [INSTR_W-1:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               drain,
  input  logic               clear,
  input  logic [INSTR_W-1:0] load_instr,
  input  logic [INSTR_W-1:0] load_pc4,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [INSTR_W-1:0] pc4
);

  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [INSTR_W-1:0] pc4_q, pc4_d;

  // Clear wins over load, load over drain.
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      instr_d = load_instr;
      pc4_d   = load_pc4;
    end else if (drain) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc4_q   <= 32'h0000_0000;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
    end
  end

  assign valid = valid_q;
  assign instr = instr_q;
  assign pc4   = pc4_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, imem request FSM, IF/ID register with backpressure and redirect.
// Optional FETCH_PERF_CNT_EN adds perf_fetched / perf_stall counters.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [INSTR_W-1:0] RESET_PC  = DEF_RESET_PC,
  parameter logic [INSTR_W-1:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic           clk,
  input  logic           rst_n,
  fetch_if.master        bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]    perf_fetched,
  output logic [31:0]    perf_stall
`endif
);

  fetch_state_e       state_q, state_d;
  logic [INSTR_W-1:0] pc_q, pc_d;
  logic               req_q, req_d;
  logic [INSTR_W-1:0] addr_q, addr_d;
  logic               id_valid_q, id_valid_d;
  logic [INSTR_W-1:0] id_instr_q, id_instr_d;
  logic [INSTR_W-1:0] id_pc4_q, id_pc4_d;

  logic               hb_load_s, hb_drain_s, hb_clear_s;
  logic               hb_valid_s;
  logic [INSTR_W-1:0] hb_instr_s, hb_pc4_s;
  logic               slot_free_s, xfer_s;

  assign xfer_s      = id_valid_q && bus.id_ready;
  assign slot_free_s = !id_valid_q || bus.id_ready;

  fetch_hold_buf #(.NOP_INSTR(NOP_INSTR)) u_hold_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (hb_load_s),
    .drain      (hb_drain_s),
    .clear      (hb_clear_s),
    .load_instr (bus.imem_rdata),
    .load_pc4   (pc_plus4(pc_q)),
    .valid      (hb_valid_s),
    .instr      (hb_instr_s),
    .pc4        (hb_pc4_s)
  );

  // Next-state, PC, request and IF/ID register computation.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_d      = req_q;
    addr_d     = addr_q;
    id_valid_d = id_valid_q;
    id_instr_d = id_instr_q;
    id_pc4_d   = id_pc4_q;
    hb_load_s  = 1'b0;
    hb_drain_s = 1'b0;
    hb_clear_s = 1'b0;

    if (bus.redirect) begin
      pc_d       = word_align(bus.redirect_pc);
      id_valid_d = 1'b0;
      id_instr_d = NOP_INSTR;
      hb_clear_s = 1'b1;
      case (state_q)
        // An unanswered request must still be retired with the old address.
        ST_REQ: begin
          if (bus.imem_ack) begin
            state_d = ST_REQ;
            req_d   = 1'b1;
            addr_d  = pc_d;
          end else begin
            state_d = ST_DROP;
          end
        end
        ST_DROP: begin
          if (bus.imem_ack) begin
            state_d = ST_REQ;
            req_d   = 1'b1;
            addr_d  = pc_d;
          end else begin
            state_d = ST_DROP;
          end
        end
        default: begin
          state_d = ST_REQ;
          req_d   = 1'b1;
          addr_d  = pc_d;
        end
      endcase
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_REQ;
          req_d   = 1'b1;
          addr_d  = pc_q;
        end
        ST_REQ: begin
          if (bus.imem_ack) begin
            pc_d   = pc_plus4(pc_q);
            addr_d = pc_plus4(pc_q);
            if (slot_free_s) begin
              id_valid_d = 1'b1;
              id_instr_d = bus.imem_rdata;
              id_pc4_d   = pc_plus4(pc_q);
            end else begin
              hb_load_s = 1'b1;
              req_d     = 1'b0;
              state_d   = ST_HOLD;
            end
          end else if (xfer_s) begin
            id_valid_d = 1'b0;
          end else begin
            id_valid_d = id_valid_q;
          end
        end
        ST_HOLD: begin
          if (bus.id_ready && hb_valid_s) begin
            id_valid_d = 1'b1;
            id_instr_d = hb_instr_s;
            id_pc4_d   = hb_pc4_s;
            hb_drain_s = 1'b1;
            req_d      = 1'b1;
            state_d    = ST_REQ;
          end else begin
            state_d = ST_HOLD;
          end
        end
        ST_DROP: begin
          if (bus.imem_ack) begin
            state_d = ST_REQ;
            req_d   = 1'b1;
            addr_d  = pc_q;
          end else begin
            state_d = ST_DROP;
          end
        end
        default: begin
          state_d = ST_IDLE;
          req_d   = 1'b0;
        end
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
      id_valid_q <= 1'b0;
      id_instr_q <= NOP_INSTR;
      id_pc4_q   <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      id_valid_q <= id_valid_d;
      id_instr_q <= id_instr_d;
      id_pc4_q   <= id_pc4_d;
    end
  end

  assign bus.imem_req  = req_q;
  assign bus.imem_addr = addr_q;
  assign bus.id_valid  = id_valid_q;
  assign bus.id_instr  = id_instr_q;
  assign bus.id_opcode = id_instr_q[OPCODE_MSB:OPCODE_LSB];
  assign bus.id_pc4    = id_pc4_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetched_q, fetched_d;
  logic [31:0] stall_q, stall_d;

  // Delivered acks exclude DROP returns and acks killed by a same-cycle redirect.
  always_comb begin
    fetched_d = fetched_q;
    stall_d   = stall_q;
    if ((state_q == ST_REQ) && bus.imem_ack && !bus.redirect) begin
      fetched_d = fetched_q + 32'd1;
    end else begin
      fetched_d = fetched_q;
    end
    if (id_valid_q && !bus.id_ready) begin
      stall_d = stall_q + 32'd1;
    end else begin
      stall_d = stall_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetched_q <= 32'd0;
      stall_q   <= 32'd0;
    end else begin
      fetched_q <= fetched_d;
      stall_q   <= stall_d;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_stall   = stall_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage (default reset PC and a wrap-around reset PC).
module tb_fetch_stage;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  fetch_if fa ();
  fetch_if fb ();

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] a_fetched, a_stall, b_fetched, b_stall;
`endif

  fetch_stage u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (fa)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched (a_fetched),
    .perf_stall   (a_stall)
`endif
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (fb)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched (b_fetched),
    .perf_stall   (b_stall)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n          = 1'b0;
    fa.imem_ack    = 1'b0;
    fa.redirect    = 1'b0;
    fb.imem_ack    = 1'b0;
    fb.redirect    = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  logic [31:0] w2 [3];
  logic [5:0]  op2 [3];

  initial begin
    n_vec = 0;
    n_err = 0;
    w2[0] = 32'h0000_0020; op2[0] = 6'b000000;
    w2[1] = 32'h0800_0004; op2[1] = 6'b000010;
    w2[2] = 32'h2001_0005; op2[2] = 6'b001000;

    rst_n          = 1'b0;
    fa.imem_ack    = 1'b0;
    fa.imem_rdata  = 32'h0000_0000;
    fa.redirect    = 1'b0;
    fa.redirect_pc = 32'h0000_0000;
    fa.id_ready    = 1'b0;
    fb.imem_ack    = 1'b0;
    fb.imem_rdata  = 32'h0000_0000;
    fb.redirect    = 1'b0;
    fb.redirect_pc = 32'h0000_0000;
    fb.id_ready    = 1'b1;

    // 1. reset values, IDLE->REQ, async reset mid-request, stray ack in IDLE
    step();
    step();
    check_eq("rst_req",      {31'd0, fa.imem_req}, 32'd0);
    check_eq("rst_addr",     fa.imem_addr,         32'h0000_0000);
    check_eq("rst_valid",    {31'd0, fa.id_valid}, 32'd0);
    check_eq("rst_instr",    fa.id_instr,          32'h0000_0000);
    check_eq("rst_pc4",      fa.id_pc4,            32'h0000_0000);
    check_eq("rst_addr_wrap", fb.imem_addr,        32'hFFFF_FFFC);
    rst_n = 1'b1;
    step();
    check_eq("post_rst_req",  {31'd0, fa.imem_req}, 32'd1);
    check_eq("post_rst_addr", fa.imem_addr,         32'h0000_0000);
    fa.imem_ack   = 1'b1;
    fa.imem_rdata = 32'h1234_5678;
    step();
    fa.imem_ack = 1'b0;
    check_eq("pre_rst_valid", {31'd0, fa.id_valid}, 32'd1);
    check_eq("pre_rst_instr", fa.id_instr,          32'h1234_5678);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_req",   {31'd0, fa.imem_req}, 32'd0);
    check_eq("async_rst_valid", {31'd0, fa.id_valid}, 32'd0);
    check_eq("async_rst_instr", fa.id_instr,          32'h0000_0000);
    @(negedge clk);
    fa.imem_ack   = 1'b1;
    fa.imem_rdata = 32'hAAAA_5555;
    rst_n         = 1'b1;
    step();
    fa.imem_ack = 1'b0;
    check_eq("stray_ack_valid", {31'd0, fa.id_valid}, 32'd0);
    check_eq("stray_ack_req",   {31'd0, fa.imem_req}, 32'd1);
    check_eq("stray_ack_addr",  fa.imem_addr,         32'h0000_0000);

    // 2. zero-wait memory, decode always ready
    fa.id_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_eq("zw_addr", fa.imem_addr, 32'(4 * i));
      fa.imem_ack   = 1'b1;
      fa.imem_rdata = w2[i];
      step();
      check_eq("zw_opcode", {26'd0, fa.id_opcode}, {26'd0, op2[i]});
      check_eq("zw_pc4",    fa.id_pc4,             32'(4 * i + 4));
      check_eq("zw_instr",  fa.id_instr,           w2[i]);
    end
    fa.imem_ack = 1'b0;
    step();
    check_eq("zw_drain_valid", {31'd0, fa.id_valid}, 32'd0);

    // 3. backpressure: second word buffered, HOLD drops request, in-order delivery
    reset_dut();
    fa.id_ready   = 1'b0;
    fa.imem_ack   = 1'b1;
    fa.imem_rdata = 32'h0000_0020;
    step();
    check_eq("bp_first_instr", fa.id_instr, 32'h0000_0020);
    fa.imem_rdata = 32'h0800_0004;
    step();
    fa.imem_ack = 1'b0;
    check_eq("bp_hold_req",   {31'd0, fa.imem_req}, 32'd0);
    check_eq("bp_hold_instr", fa.id_instr,          32'h0000_0020);
    step();
    check_eq("bp_hold_pc4",   fa.id_pc4,            32'h0000_0004);
    check_eq("bp_hold_valid", {31'd0, fa.id_valid}, 32'd1);
    step();
    check_eq("bp_hold_instr3", fa.id_instr,          32'h0000_0020);
    check_eq("bp_hold_req3",   {31'd0, fa.imem_req}, 32'd0);
    fa.id_ready = 1'b1;
    step();
    check_eq("bp_second_instr", fa.id_instr,          32'h0800_0004);
    check_eq("bp_second_pc4",   fa.id_pc4,            32'h0000_0008);
    check_eq("bp_resume_req",   {31'd0, fa.imem_req}, 32'd1);
    check_eq("bp_resume_addr",  fa.imem_addr,         32'h0000_0008);
`ifdef FETCH_PERF_CNT_EN
    check_eq("perf_stall",   a_stall,   32'd3);
    check_eq("perf_fetched", a_fetched, 32'd2);
`endif
    step();
    check_eq("bp_empty_valid", {31'd0, fa.id_valid}, 32'd0);

    // 4. redirect while a two-cycle-latency request is outstanding
    reset_dut();
    fa.id_ready = 1'b1;
    step();
    fa.redirect    = 1'b1;
    fa.redirect_pc = 32'h0000_0040;
    step();
    fa.redirect = 1'b0;
    check_eq("drop_req",   {31'd0, fa.imem_req}, 32'd1);
    check_eq("drop_addr",  fa.imem_addr,         32'h0000_0000);
    check_eq("drop_valid", {31'd0, fa.id_valid}, 32'd0);
    fa.imem_ack   = 1'b1;
    fa.imem_rdata = 32'hDEAD_BEEF;
    step();
    fa.imem_ack = 1'b0;
    check_eq("drop_new_addr", fa.imem_addr,         32'h0000_0040);
    check_eq("drop_discard",  {31'd0, fa.id_valid}, 32'd0);
    step();
    check_eq("drop_wait_valid", {31'd0, fa.id_valid}, 32'd0);
    fa.imem_ack   = 1'b1;
    fa.imem_rdata = 32'h8C22_0000;
    step();
    fa.imem_ack = 1'b0;
    check_eq("tgt_valid",  {31'd0, fa.id_valid},   32'd1);
    check_eq("tgt_instr",  fa.id_instr,            32'h8C22_0000);
    check_eq("tgt_pc4",    fa.id_pc4,              32'h0000_0044);
    check_eq("tgt_opcode", {26'd0, fa.id_opcode},  32'h0000_0023);

    // 5. redirect to an unaligned target coincident with ack
    fa.imem_ack    = 1'b1;
    fa.imem_rdata  = 32'hFFFF_FFFF;
    fa.redirect    = 1'b1;
    fa.redirect_pc = 32'h0000_0043;
    step();
    fa.redirect = 1'b0;
    fa.imem_ack = 1'b0;
    check_eq("rack_valid", {31'd0, fa.id_valid}, 32'd0);
    check_eq("rack_instr", fa.id_instr,          32'h0000_0000);
    check_eq("rack_addr",  fa.imem_addr,         32'h0000_0040);
    check_eq("rack_req",   {31'd0, fa.imem_req}, 32'd1);
    fa.imem_ack   = 1'b1;
    fa.imem_rdata = 32'h1000_0001;
    step();
    fa.imem_ack = 1'b0;
    check_eq("rack_tgt_instr",  fa.id_instr,           32'h1000_0001);
    check_eq("rack_tgt_pc4",    fa.id_pc4,             32'h0000_0044);
    check_eq("rack_tgt_opcode", {26'd0, fa.id_opcode}, 32'h0000_0004);

    // 6. PC wrap from 0xFFFFFFFC
    reset_dut();
    check_eq("wrap_first_addr", fb.imem_addr,         32'hFFFF_FFFC);
    check_eq("wrap_first_req",  {31'd0, fb.imem_req}, 32'd1);
    fb.imem_ack   = 1'b1;
    fb.imem_rdata = 32'h0000_0020;
    step();
    fb.imem_ack = 1'b0;
    check_eq("wrap_pc4",    fb.id_pc4,            32'h0000_0000);
    check_eq("wrap_addr",   fb.imem_addr,         32'h0000_0000);
    check_eq("wrap_valid",  {31'd0, fb.id_valid}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
